// File: rtl/osecpu_run_monitor.sv
// osecpu_run_monitor: run controller/monitor for one OSECPU program run.
// On start it holds the CPU in reset for RESET_CYCLES cycles, then releases it
// and counts run cycles. On the halt flag it captures DR/PC and checks DR
// against the value latched at start. If the cycle limit is reached first,
// the run is aborted and flagged as a timeout.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               1-cycle run request (honoured in IDLE and DONE only)
//   expect_en/_val      DR compare enable/value, latched at start
//   cpu_dr/cr/pc        OSECPU data register, control register, program counter
//   cpu_reset           reset to OSECPU, active-high (low only while running)
//   busy, done          run in progress / run finished
//   pass, fail, timeout run status, valid while done
//   result, halt_pc     DR and PC captured at halt (zero on timeout)
//   cycles              RUN cycles elapsed, saturating

`ifndef BIT_CR_HLT
`define BIT_CR_HLT 0
`endif

module osecpu_run_monitor #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned PC_WIDTH       = 16,
    parameter int unsigned CR_WIDTH       = 8,
    parameter int unsigned HLT_BIT        = `BIT_CR_HLT,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 2000,
    parameter int unsigned RESET_CYCLES   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         expect_en,
    input  logic signed [DATA_WIDTH-1:0] expect_val,
    input  logic signed [DATA_WIDTH-1:0] cpu_dr,
    input  logic        [CR_WIDTH-1:0]   cpu_cr,
    input  logic        [PC_WIDTH-1:0]   cpu_pc,
    output logic                         cpu_reset,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic                         timeout,
    output logic signed [DATA_WIDTH-1:0] result,
    output logic        [PC_WIDTH-1:0]   halt_pc,
    output logic        [CNT_WIDTH-1:0]  cycles
);

    // Hold counter wide enough for RESET_CYCLES (and safe if it is set to 0).
    localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 2);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_K  = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam bit                   TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RESET_HOLD = 2'd1,
        ST_RUN        = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

    state_t                         state;
    logic        [HOLD_W-1:0]       hold_cnt;
    logic                           exp_en_q;
    logic signed [DATA_WIDTH-1:0]   exp_val_q;

    logic                           start_ok_c;
    logic                           halt_c;
    logic                           halt_pass_c;
    logic                           timeout_hit_c;
    logic        [CNT_WIDTH-1:0]    cycles_inc_c;
    logic                           unused_cr_c;

    // Only the halt bit of the control register is observed.
    assign unused_cr_c = ^cpu_cr;

    // Decode of the current cycle's events.
    always_comb begin
        start_ok_c    = start && ((state == ST_IDLE) || (state == ST_DONE));
        halt_c        = cpu_cr[HLT_BIT];
        halt_pass_c   = !exp_en_q || (cpu_dr == exp_val_q);
        cycles_inc_c  = (&cycles) ? cycles : cycles + CNT_WIDTH'(1);
        timeout_hit_c = TIMEOUT_EN && (cycles_inc_c == TIMEOUT_K);
    end

    // Run controller: state, status and captured values, all registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            result    <= '0;
            halt_pc   <= '0;
            cycles    <= '0;
            hold_cnt  <= '0;
            exp_en_q  <= 1'b0;
            exp_val_q <= '0;
        end else if (start_ok_c) begin
            // New run from IDLE or DONE: clear status, latch the compare setup.
            state     <= ST_RESET_HOLD;
            cpu_reset <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            result    <= '0;
            halt_pc   <= '0;
            cycles    <= '0;
            hold_cnt  <= HOLD_W'(RESET_CYCLES);
            exp_en_q  <= expect_en;
            exp_val_q <= expect_val;
        end else begin
            case (state)
                ST_RESET_HOLD: begin
                    // Last hold cycle: release the CPU at this edge.
                    if (hold_cnt <= HOLD_W'(1)) begin
                        state     <= ST_RUN;
                        cpu_reset <= 1'b0;
                        cycles    <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    cycles <= cycles_inc_c;
                    // Halt takes priority over a timeout in the same cycle.
                    if (halt_c) begin
                        state     <= ST_DONE;
                        cpu_reset <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= cpu_dr;
                        halt_pc   <= cpu_pc;
                        pass      <= halt_pass_c;
                        fail      <= !halt_pass_c;
                        timeout   <= 1'b0;
                    end else if (timeout_hit_c) begin
                        state     <= ST_DONE;
                        cpu_reset <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        fail      <= 1'b1;
                        timeout   <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE hold until start or reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osecpu_run_monitor.sv
// tb_osecpu_run_monitor: directed bench for osecpu_run_monitor.
// dut_a (RESET_CYCLES=1, TIMEOUT=100) is checked through a scoreboard that
// pops expected status when done rises; dut_b (RESET_CYCLES=3, TIMEOUT=2000)
// covers the longer reset hold and start handling in RUN and DONE.
// Each DUT is driven by a tiny CPU model that counts cycles out of reset and
// raises the halt flag on a chosen RUN cycle with a chosen DR value.

module tb_osecpu_run_monitor;

    localparam int unsigned DW = 32;
    localparam int unsigned PW = 16;
    localparam int unsigned CW = 8;
    localparam int unsigned NW = 32;
    localparam int unsigned HB = 0;

    typedef struct packed {
        logic          pass;
        logic          fail;
        logic          timeout;
        logic [DW-1:0] result;
        logic [PW-1:0] halt_pc;
        logic [NW-1:0] cycles;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset      = 1'b1;
    logic          start_a    = 1'b0;
    logic          start_b    = 1'b0;
    logic          expect_en  = 1'b0;
    logic [DW-1:0] expect_val = '0;

    // CPU models: halt_x = RUN cycle on which halt is raised (0 = never).
    logic [NW-1:0] cnt_a = '0, cnt_b = '0;
    logic [NW-1:0] halt_a = '0, halt_b = '0;
    logic [DW-1:0] dr_a = '0, dr_b = '0;
    logic          hit_a, hit_b;
    logic [DW-1:0] cpu_dr_a, cpu_dr_b;
    logic [CW-1:0] cpu_cr_a, cpu_cr_b;
    logic [PW-1:0] cpu_pc_a, cpu_pc_b;

    logic          cpu_reset_a, busy_a, done_a, pass_a, fail_a, timeout_a;
    logic [DW-1:0] result_a;
    logic [PW-1:0] halt_pc_a;
    logic [NW-1:0] cycles_a;
    logic          cpu_reset_b, busy_b, done_b, pass_b, fail_b, timeout_b;
    logic [DW-1:0] result_b;
    logic [PW-1:0] halt_pc_b;
    logic [NW-1:0] cycles_b;

    always @(posedge clk) cnt_a <= cpu_reset_a ? '0 : cnt_a + NW'(1);
    always @(posedge clk) cnt_b <= cpu_reset_b ? '0 : cnt_b + NW'(1);

    assign hit_a    = !cpu_reset_a && (halt_a != '0) && (cnt_a + NW'(1) == halt_a);
    assign hit_b    = !cpu_reset_b && (halt_b != '0) && (cnt_b + NW'(1) == halt_b);
    assign cpu_cr_a = CW'(hit_a) << HB;
    assign cpu_cr_b = CW'(hit_b) << HB;
    assign cpu_dr_a = hit_a ? dr_a : cnt_a;
    assign cpu_dr_b = hit_b ? dr_b : cnt_b;
    assign cpu_pc_a = 16'h0100 + cnt_a[PW-1:0];
    assign cpu_pc_b = 16'h0100 + cnt_b[PW-1:0];

    osecpu_run_monitor #(
        .DATA_WIDTH(DW), .PC_WIDTH(PW), .CR_WIDTH(CW), .HLT_BIT(HB),
        .CNT_WIDTH(NW), .TIMEOUT_CYCLES(100), .RESET_CYCLES(1)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .expect_en(expect_en), .expect_val(expect_val),
        .cpu_dr(cpu_dr_a), .cpu_cr(cpu_cr_a), .cpu_pc(cpu_pc_a),
        .cpu_reset(cpu_reset_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .fail(fail_a), .timeout(timeout_a),
        .result(result_a), .halt_pc(halt_pc_a), .cycles(cycles_a)
    );

    osecpu_run_monitor #(
        .DATA_WIDTH(DW), .PC_WIDTH(PW), .CR_WIDTH(CW), .HLT_BIT(HB),
        .CNT_WIDTH(NW), .TIMEOUT_CYCLES(2000), .RESET_CYCLES(3)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .expect_en(expect_en), .expect_val(expect_val),
        .cpu_dr(cpu_dr_b), .cpu_cr(cpu_cr_b), .cpu_pc(cpu_pc_b),
        .cpu_reset(cpu_reset_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .fail(fail_b), .timeout(timeout_b),
        .result(result_b), .halt_pc(halt_pc_b), .cycles(cycles_b)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for dut_a: one expected status per run, checked when done rises.
    logic done_q = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done_a && !done_q) begin
            check("sb_entry_present", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_pass",    32'(pass_a),    32'(e.pass));
                check("sb_fail",    32'(fail_a),    32'(e.fail));
                check("sb_timeout", 32'(timeout_a), 32'(e.timeout));
                check("sb_result",  result_a,       e.result);
                check("sb_halt_pc", 32'(halt_pc_a), 32'(e.halt_pc));
                check("sb_cycles",  cycles_a,       e.cycles);
            end
        end
        done_q = done_a;
    end

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic pulse_start_b();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (!done_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_done_a", 32'(done_a), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_done_b(input int budget);
        int n = 0;
        while (!done_b && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_done_b", 32'(done_b), 32'd1);
    endtask

    initial begin
        int n;
        exp_t e;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cpu_reset", 32'(cpu_reset_a), 32'd1);
        check("rst_busy",      32'(busy_a),      32'd0);
        check("rst_done",      32'(done_a),      32'd0);
        check("rst_status",    32'({pass_a, fail_a, timeout_a}), 32'd0);
        check("rst_result",    result_a,         32'd0);
        check("rst_cycles",    cycles_a,         32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: halt on RUN cycle 50 with DR=-4, expect -4 -> pass
        halt_a = 32'd50; dr_a = 32'hFFFF_FFFC;
        expect_en = 1'b1; expect_val = 32'hFFFF_FFFC;
        e = '{pass: 1'b1, fail: 1'b0, timeout: 1'b0, result: 32'hFFFF_FFFC,
              halt_pc: 16'h0131, cycles: 32'd50};
        sb_q.push_back(e);
        pulse_start_a();
        expect_val = 32'd0;  // must not matter: latched at start
        check("t1_hold_cpu_reset", 32'(cpu_reset_a), 32'd1);
        check("t1_hold_busy",      32'(busy_a),      32'd1);
        @(negedge clk);
        check("t1_run_cpu_reset",  32'(cpu_reset_a), 32'd0);
        check("t1_run_cycles0",    cycles_a,         32'd0);
        wait_done_a(200);
        check("t1_cpu_frozen",     32'(cpu_reset_a), 32'd1);

        // 2: same program, expect 5 -> fail without timeout
        expect_val = 32'd5;
        e = '{pass: 1'b0, fail: 1'b1, timeout: 1'b0, result: 32'hFFFF_FFFC,
              halt_pc: 16'h0131, cycles: 32'd50};
        sb_q.push_back(e);
        pulse_start_a();
        check("t2_done_drops", 32'(done_a), 32'd0);
        wait_done_a(200);

        // 3: no halt -> timeout on RUN cycle 100
        halt_a = '0;
        e = '{pass: 1'b0, fail: 1'b1, timeout: 1'b1, result: 32'd0,
              halt_pc: 16'h0000, cycles: 32'd100};
        sb_q.push_back(e);
        pulse_start_a();
        wait_done_a(300);

        // 4: halt exactly on the timeout cycle, compare disabled -> halt wins
        halt_a = 32'd100; dr_a = 32'h1234_5678;
        expect_en = 1'b0; expect_val = 32'd1;
        e = '{pass: 1'b1, fail: 1'b0, timeout: 1'b0, result: 32'h1234_5678,
              halt_pc: 16'h0163, cycles: 32'd100};
        sb_q.push_back(e);
        pulse_start_a();
        wait_done_a(300);

        // 5: dut_b, 3-cycle reset hold, start ignored in RUN, restart from DONE
        halt_b = 32'd30; dr_b = 32'd7;
        expect_en = 1'b1; expect_val = 32'd7;
        pulse_start_b();
        check("t5_hold1", 32'(cpu_reset_b), 32'd1);
        @(negedge clk);
        check("t5_hold2", 32'(cpu_reset_b), 32'd1);
        @(negedge clk);
        check("t5_hold3", 32'(cpu_reset_b), 32'd1);
        @(negedge clk);
        check("t5_released", 32'(cpu_reset_b), 32'd0);
        check("t5_cycles0",  cycles_b,         32'd0);
        repeat (5) @(negedge clk);
        pulse_start_b();
        check("t5_run_start_busy",   32'(busy_b),      32'd1);
        check("t5_run_start_cpurst", 32'(cpu_reset_b), 32'd0);
        check("t5_run_start_cycles", cycles_b,         32'd6);
        wait_done_b(100);
        check("t5_pass",    32'({pass_b, fail_b, timeout_b}), 32'b100);
        check("t5_result",  result_b,          32'd7);
        check("t5_halt_pc", 32'(halt_pc_b),    32'h011D);
        check("t5_cycles",  cycles_b,          32'd30);
        @(negedge clk);
        halt_b = 32'd40; expect_val = 32'd8;
        pulse_start_b();
        check("t5_restart_done",   32'(done_b),      32'd0);
        check("t5_restart_busy",   32'(busy_b),      32'd1);
        check("t5_restart_status", 32'({pass_b, fail_b, timeout_b}), 32'd0);
        check("t5_restart_result", result_b,         32'd0);
        check("t5_restart_cycles", cycles_b,         32'd0);
        check("t5_restart_cpurst", 32'(cpu_reset_b), 32'd1);
        wait_done_b(100);
        check("t5b_status", 32'({pass_b, fail_b, timeout_b}), 32'b010);
        check("t5b_cycles", cycles_b,          32'd40);
        check("t5b_result", result_b,          32'd7);

        // 6: reset mid-RUN at cycle 20
        halt_a = '0;
        pulse_start_a();
        n = 0;
        while (cycles_a != 32'd20 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_reached_20", cycles_a, 32'd20);
        reset = 1'b1;
        @(negedge clk);
        check("t6_cpu_reset", 32'(cpu_reset_a), 32'd1);
        check("t6_busy",      32'(busy_a),      32'd0);
        check("t6_done",      32'(done_a),      32'd0);
        check("t6_cycles",    cycles_a,         32'd0);
        check("t6_status",    32'({pass_a, fail_a, timeout_a}), 32'd0);

        // start together with reset: reset wins
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("t6_rst_start_busy", 32'(busy_a), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_idle_busy", 32'(busy_a), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
